pipe_stage_chain: RTL and testbench

- Parametrised pipeline-register chain for the five-stage core. It is the generalised successor of the fixed ID/EX latch.
- Carries a control bundle and a data bundle through DEPTH register stages, each stage with its own valid bit.
- Supports a global hold (memory stall), a flush that squashes every stage, and bubble insertion at the entry stage for load-use hazards.
- Invalid stages always present the safe bubble control word, so downstream write enables stay inert.

---
 rtl/pipe_stage_chain.sv | 82 ++++++++
 tb/tb_pipe_stage_chain.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline-register chain carrying a control and a data bundle through DEPTH stages.
// It supports a global hold, a flush of every stage, and bubble insertion at the entry stage.
module pipe_stage_chain #(
    parameter int unsigned       CTRL_W      = 7,
    parameter int unsigned       DATA_W      = 121,
    parameter int unsigned       DEPTH       = 1,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         stall_i,
    input  logic                         flush_i,
    input  logic                         bubble_i,
    input  logic                         valid_i,
    input  logic [CTRL_W-1:0]            ctrl_i,
    input  logic [DATA_W-1:0]            data_i,
    output logic                         valid_o,
    output logic [CTRL_W-1:0]            ctrl_o,
    output logic [DATA_W-1:0]            data_o,
    output logic [DEPTH-1:0]             stage_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("pipe_stage_chain: DEPTH must be in 1..8");
    end

    logic [DEPTH-1:0]  vld_q;
    logic [CTRL_W-1:0] ctl_q [DEPTH];
    logic [DATA_W-1:0] dat_q [DEPTH];
    logic [OCC_W-1:0]  occ_q;

    logic              v0_next;
    logic [OCC_W-1:0]  occ_next;

    // Occupancy is tracked incrementally: an entering valid adds one, a departing valid removes one.
    always_comb begin
        v0_next  = 1'b0;
        occ_next = occ_q;
        v0_next  = bubble_i ? 1'b0 : valid_i;
        occ_next = occ_q + OCC_W'(v0_next) - OCC_W'(vld_q[DEPTH-1]);
    end

    // Priority: reset > flush > stall > bubble > advance; invalid stages always hold the bubble word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                ctl_q[k] <= CTRL_BUBBLE;
                dat_q[k] <= '0;
            end
        end else if (flush_i) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                ctl_q[k] <= CTRL_BUBBLE;
            end
        end else if (!stall_i) begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                vld_q[k] <= vld_q[k-1];
                ctl_q[k] <= ctl_q[k-1];
                dat_q[k] <= dat_q[k-1];
            end
            vld_q[0] <= v0_next;
            ctl_q[0] <= v0_next ? ctrl_i : CTRL_BUBBLE;
            if (!bubble_i) begin
                dat_q[0] <= data_i;
            end
            occ_q <= occ_next;
        end
    end

    assign valid_o       = vld_q[DEPTH-1];
    assign ctrl_o        = ctl_q[DEPTH-1];
    assign data_o        = dat_q[DEPTH-1];
    assign stage_valid_o = vld_q;
    assign occupancy_o   = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: three instances (DEPTH 3, 2, 1) share one stimulus set.
module tb_pipe_stage_chain;

    localparam int unsigned CW = 7;
    localparam int unsigned DW = 121;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          stall_i = 1'b0, flush_i = 1'b0, bubble_i = 1'b0, valid_i = 1'b0;
    logic [CW-1:0] ctrl_i = '0;
    logic [DW-1:0] data_i = '0;

    logic          v3, v2, v1;
    logic [CW-1:0] c3, c2, c1;
    logic [DW-1:0] d3, d2, d1;
    logic [2:0]    sv3;
    logic [1:0]    sv2;
    logic [0:0]    sv1;
    logic [1:0]    o3, o2;
    logic [0:0]    o1;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_chain #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3), .CTRL_BUBBLE('0)) u3 (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .bubble_i(bubble_i),
        .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(v3), .ctrl_o(c3),
        .data_o(d3), .stage_valid_o(sv3), .occupancy_o(o3));

    pipe_stage_chain #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2), .CTRL_BUBBLE('0)) u2 (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .bubble_i(bubble_i),
        .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(v2), .ctrl_o(c2),
        .data_o(d2), .stage_valid_o(sv2), .occupancy_o(o2));

    pipe_stage_chain #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1), .CTRL_BUBBLE('0)) u1 (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .bubble_i(bubble_i),
        .valid_i(valid_i), .ctrl_i(ctrl_i), .data_i(data_i), .valid_o(v1), .ctrl_o(c1),
        .data_o(d1), .stage_valid_o(sv1), .occupancy_o(o1));

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        valid_i = v;
        ctrl_i  = c;
        data_i  = d;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        stall_i = 1'b0; flush_i = 1'b0; bubble_i = 1'b0;
        drive(1'b0, '0, '0);
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        total++; if (v3 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", v3); end
        total++; if (c3 !== 7'h00) begin bad++; $display("FAIL reset_ctrl got=%h exp=00", c3); end
        total++; if (sv3 !== 3'b000) begin bad++; $display("FAIL reset_stage_valid got=%b exp=000", sv3); end
        total++; if (o3 !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", o3); end
        rst_i = 1'b0;
        // Fill DEPTH=3 with three valid ops, then reset between edges.
        drive(1'b1, 7'h11, DW'(121'h101)); step();
        drive(1'b1, 7'h12, DW'(121'h102)); step();
        drive(1'b1, 7'h13, DW'(121'h103)); step();
        total++; if (o3 !== 2'd3) begin bad++; $display("FAIL full_occ got=%0d exp=3", o3); end
        total++; if (c3 !== 7'h11 || d3 !== DW'(121'h101)) begin
            bad++; $display("FAIL full_out got=%h/%h exp=11/101", c3, d3); end
        #3;
        rst_i = 1'b1;
        #1;
        total++; if (v3 !== 1'b0) begin bad++; $display("FAIL async_rst_valid got=%0b exp=0", v3); end
        total++; if (c3 !== 7'h00) begin bad++; $display("FAIL async_rst_ctrl got=%h exp=00", c3); end
        total++; if (d3 !== '0) begin bad++; $display("FAIL async_rst_data got=%h exp=0", d3); end
        total++; if (o3 !== 2'd0) begin bad++; $display("FAIL async_rst_occ got=%0d exp=0", o3); end
        total++; if (sv3 !== 3'b000) begin bad++; $display("FAIL async_rst_sv got=%b exp=000", sv3); end
    endtask

    task automatic test_latency();
        logic [1:0] occ_exp [4];
        occ_exp[0] = 2'd1; occ_exp[1] = 2'd1; occ_exp[2] = 2'd1; occ_exp[3] = 2'd0;
        do_reset();
        drive(1'b1, 7'h55, DW'(121'h1234));
        for (int e = 0; e < 4; e++) begin
            step();
            drive(1'b0, 7'h2A, DW'(121'hBEEF));
            total++; if (o3 !== occ_exp[e]) begin
                bad++; $display("FAIL lat_occ edge=%0d got=%0d exp=%0d", e + 1, o3, occ_exp[e]); end
            total++; if (v3 !== (e == 2)) begin
                bad++; $display("FAIL lat_valid edge=%0d got=%0b exp=%0b", e + 1, v3, (e == 2)); end
            if (e == 2) begin
                total++; if (c3 !== 7'h55 || d3 !== DW'(121'h1234)) begin
                    bad++; $display("FAIL lat_payload got=%h/%h exp=55/1234", c3, d3); end
            end else begin
                total++; if (c3 !== 7'h00) begin
                    bad++; $display("FAIL lat_bubble_ctrl edge=%0d got=%h exp=00", e + 1, c3); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 7'h11, DW'(121'hA1)); step();
        drive(1'b1, 7'h22, DW'(121'hB2)); step();
        drive(1'b1, 7'h33, DW'(121'hC3));
        stall_i = 1'b1;
        bubble_i = 1'b1;
        for (int e = 0; e < 4; e++) begin
            step();
            total++; if (v2 !== 1'b1 || c2 !== 7'h11 || d2 !== DW'(121'hA1)) begin
                bad++; $display("FAIL stall_out cyc=%0d got=%0b/%h/%h exp=1/11/a1", e, v2, c2, d2); end
            total++; if (o2 !== 2'd2 || sv2 !== 2'b11) begin
                bad++; $display("FAIL stall_occ cyc=%0d got=%0d/%b exp=2/11", e, o2, sv2); end
        end
        stall_i = 1'b0;
        bubble_i = 1'b0;
        step();
        drive(1'b0, '0, '0);
        total++; if (v2 !== 1'b1 || c2 !== 7'h22 || d2 !== DW'(121'hB2) || o2 !== 2'd2) begin
            bad++; $display("FAIL stall_rel_b got=%0b/%h/%h/%0d exp=1/22/b2/2", v2, c2, d2, o2); end
        step();
        total++; if (v2 !== 1'b1 || c2 !== 7'h33 || d2 !== DW'(121'hC3) || o2 !== 2'd1) begin
            bad++; $display("FAIL stall_rel_c got=%0b/%h/%h/%0d exp=1/33/c3/1", v2, c2, d2, o2); end
    endtask

    task automatic test_flush_stall();
        do_reset();
        drive(1'b1, 7'h41, DW'(121'h4141)); step();
        drive(1'b1, 7'h42, DW'(121'h4242)); step();
        total++; if (o2 !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", o2); end
        stall_i = 1'b1; flush_i = 1'b1; bubble_i = 1'b1;
        step();
        stall_i = 1'b0; flush_i = 1'b0; bubble_i = 1'b0;
        drive(1'b0, '0, '0);
        total++; if (sv2 !== 2'b00 || v2 !== 1'b0) begin
            bad++; $display("FAIL flush_sv got=%b/%0b exp=00/0", sv2, v2); end
        total++; if (c2 !== 7'h00) begin bad++; $display("FAIL flush_ctrl got=%h exp=00", c2); end
        total++; if (o2 !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", o2); end
        total++; if (d2 !== DW'(121'h4141)) begin bad++; $display("FAIL flush_data_hold got=%h exp=4141", d2); end
    endtask

    task automatic test_bubble();
        do_reset();
        drive(1'b1, 7'h0A, DW'(121'hA)); step();
        total++; if (sv2 !== 2'b01 || o2 !== 2'd1) begin
            bad++; $display("FAIL bub_e1 got=%b/%0d exp=01/1", sv2, o2); end
        drive(1'b1, 7'h0B, DW'(121'hB));
        bubble_i = 1'b1;
        step();
        bubble_i = 1'b0;
        total++; if (sv2 !== 2'b10 || o2 !== 2'd1 || c2 !== 7'h0A || d2 !== DW'(121'hA)) begin
            bad++; $display("FAIL bub_e2 got=%b/%0d/%h/%h exp=10/1/0a/a", sv2, o2, c2, d2); end
        step();
        total++; if (sv2 !== 2'b01 || o2 !== 2'd1 || v2 !== 1'b0 || c2 !== 7'h00) begin
            bad++; $display("FAIL bub_hole got=%b/%0d/%0b/%h exp=01/1/0/00", sv2, o2, v2, c2); end
        total++; if (d2 !== DW'(121'hA)) begin bad++; $display("FAIL bub_data_hold got=%h exp=a", d2); end
        drive(1'b1, 7'h0C, DW'(121'hC)); step();
        total++; if (sv2 !== 2'b11 || o2 !== 2'd2 || c2 !== 7'h0B || d2 !== DW'(121'hB)) begin
            bad++; $display("FAIL bub_e4 got=%b/%0d/%h/%h exp=11/2/0b/b", sv2, o2, c2, d2); end
        drive(1'b0, '0, '0); step();
        total++; if (sv2 !== 2'b10 || o2 !== 2'd1 || c2 !== 7'h0C) begin
            bad++; $display("FAIL bub_e5 got=%b/%0d/%h exp=10/1/0c", sv2, o2, c2); end
        stall_i = 1'b1; bubble_i = 1'b1;
        step();
        stall_i = 1'b0; bubble_i = 1'b0;
        total++; if (sv2 !== 2'b10 || o2 !== 2'd1 || c2 !== 7'h0C) begin
            bad++; $display("FAIL bub_stalled got=%b/%0d/%h exp=10/1/0c", sv2, o2, c2); end
    endtask

    task automatic test_gating();
        do_reset();
        drive(1'b0, 7'h7F, DW'(121'h5)); step();
        total++; if (v1 !== 1'b0 || c1 !== 7'h00 || o1 !== 1'b0) begin
            bad++; $display("FAIL gate_invalid got=%0b/%h/%0d exp=0/00/0", v1, c1, o1); end
        total++; if (d1 !== DW'(121'h5)) begin bad++; $display("FAIL gate_data got=%h exp=5", d1); end
        drive(1'b1, 7'h7F, DW'(121'h6)); step();
        total++; if (v1 !== 1'b1 || c1 !== 7'h7F || o1 !== 1'b1 || sv1 !== 1'b1) begin
            bad++; $display("FAIL gate_valid got=%0b/%h/%0d/%b exp=1/7f/1/1", v1, c1, o1, sv1); end
        bubble_i = 1'b1; step();
        bubble_i = 1'b0;
        total++; if (v1 !== 1'b0 || c1 !== 7'h00 || o1 !== 1'b0 || d1 !== DW'(121'h6)) begin
            bad++; $display("FAIL gate_bubble got=%0b/%h/%0d/%h exp=0/00/0/6", v1, c1, o1, d1); end
        step();
        total++; if (v1 !== 1'b1 || c1 !== 7'h7F || o1 !== 1'b1) begin
            bad++; $display("FAIL gate_d1_reload got=%0b/%h/%0d exp=1/7f/1", v1, c1, o1); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_flush_stall();
        test_bubble();
        test_gating();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
